// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between an issuing controller and alu_serial_ctrl.
// The controller side is the master; the sequencer is the slave.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_flag;
  logic             err;

  modport master (
    output start, op_sel, op_a, op_b, op_cin,
    input  busy, done, result, carry_flag, err
  );

  modport slave (
    input  start, op_sel, op_a, op_b, op_cin,
    output busy, done, result, carry_flag, err
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer around a combinational 1-bit ALU slice: drives operands
// LSB first, feeds the carry back and assembles a WIDTH-bit result.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_serial_ctrl_if.slave   ctrl,
  output logic               slice_a,
  output logic               slice_b,
  output logic               slice_cin,
  output logic [3:0]         slice_sel,
  input  logic               slice_res,
  input  logic               slice_cout
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_LT   = 4'b0100;
  localparam logic [3:0] SEL_OFF = 4'b1111;

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, result_q;
  logic [3:0]       op_q;
  logic             carry_q, carry_flag_q, err_q;
  logic [CNT_W-1:0] cnt;
  logic             op_ok, is_arith, last_bit;

  assign op_ok    = ctrl.op_sel <= OP_LT;
  assign is_arith = (ctrl.op_sel == OP_ADD) || (ctrl.op_sel == OP_SUB);
  assign last_bit = cnt == CNT_LAST;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ctrl.start) state_nxt = op_ok ? RUN : DONE;
      RUN:     if (last_bit)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // LT is run as a serial subtract; its final borrow is the comparison result.
  always_comb begin
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_sel = SEL_OFF;
    if (state == RUN) begin
      slice_a   = a_sr[0];
      slice_b   = b_sr[0];
      slice_cin = carry_q;
      slice_sel = (op_q == OP_LT) ? OP_SUB : op_q;
    end
  end

  // res_sr collects serial bits; result_q only moves at accept and RUN exit so
  // the visible result stays stable from done until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr         <= '0;
      b_sr         <= '0;
      res_sr       <= '0;
      result_q     <= '0;
      op_q         <= '0;
      carry_q      <= 1'b0;
      carry_flag_q <= 1'b0;
      err_q        <= 1'b0;
      cnt          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctrl.start) begin
            result_q     <= '0;
            carry_flag_q <= 1'b0;
            err_q        <= !op_ok;
            if (op_ok) begin
              a_sr    <= ctrl.op_a;
              b_sr    <= ctrl.op_b;
              op_q    <= ctrl.op_sel;
              carry_q <= is_arith ? ctrl.op_cin : 1'b0;
              res_sr  <= '0;
              cnt     <= '0;
            end
          end
        end
        RUN: begin
          res_sr  <= {slice_res, res_sr[WIDTH-1:1]};
          carry_q <= slice_cout;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            carry_flag_q <= ((op_q == OP_AND) || (op_q == OP_OR)) ? 1'b0 : slice_cout;
            result_q     <= (op_q == OP_LT) ? {{(WIDTH-1){1'b0}}, slice_cout}
                                            : {slice_res, res_sr[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign ctrl.busy       = state == RUN;
  assign ctrl.done       = state == DONE;
  assign ctrl.result     = result_q;
  assign ctrl.carry_flag = carry_flag_q;
  assign ctrl.err        = err_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl: a behavioural slice model, a stimulus
// process pushing expectations and a monitor comparing on done / in RUN.
module tb_alu_serial_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] result;
    logic         carry;
    logic         err;
    int           cyc;
  } exp_t;

  typedef struct {
    int           first;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
  } win_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slice_a, slice_b, slice_cin, slice_res, slice_cout;
  logic [3:0] slice_sel;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       sb[$];
  win_t       wq[$];

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl       (bus),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sel  (slice_sel),
    .slice_res  (slice_res),
    .slice_cout (slice_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference 1-bit slice: SUB produces difference and borrow-out.
  always_comb begin
    slice_res  = 1'b0;
    slice_cout = 1'b0;
    case (slice_sel)
      4'b0000: slice_res = slice_a & slice_b;
      4'b0001: slice_res = slice_a | slice_b;
      4'b0010: begin
        slice_res  = slice_a ^ slice_b ^ slice_cin;
        slice_cout = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
      end
      4'b0011: begin
        slice_res  = slice_a ^ slice_b ^ slice_cin;
        slice_cout = (~slice_a & slice_b) | (slice_cin & ~(slice_a ^ slice_b));
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       bus.busy, 0);
    check({tag, "_done"},       bus.done, 0);
    check({tag, "_result"},     bus.result, 0);
    check({tag, "_carry_flag"}, bus.carry_flag, 0);
    check({tag, "_err"},        bus.err, 0);
    check({tag, "_slice_abc"},  {slice_a, slice_b, slice_cin}, 0);
    check({tag, "_slice_sel"},  slice_sel, 4'b1111);
  endtask

  // Monitor: per-cycle slice drive during RUN, scoreboard pop on done.
  always @(negedge clk) begin : monitor
    int   i;
    exp_t e;
    if (rst_n) begin
      if (wq.size() > 0 && cyc >= wq[0].first && cyc < wq[0].first + W) begin
        i = cyc - wq[0].first;
        check("run_busy",    bus.busy, 1);
        check("run_result",  {bus.result, bus.carry_flag}, 0);
        check("run_sel",     slice_sel, wq[0].sel);
        check("run_slice_a", slice_a, wq[0].a[i]);
        check("run_slice_b", slice_b, wq[0].b[i]);
        if (i == W - 1) void'(wq.pop_front());
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", bus.done, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("result",     bus.result, e.result);
          check("carry_flag", bus.carry_flag, e.carry);
          check("err",        bus.err, e.err);
          check("done_busy",  bus.busy, 0);
        end
      end
    end
  end

  // Called at negedge+1 with the DUT idle; one accept edge follows.
  task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] r, input logic c, input logic e);
    int acc;
    acc = cyc + 1;
    bus.start  = 1'b1;
    bus.op_sel = op;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.op_cin = cin;
    sb.push_back('{result: r, carry: c, err: e, cyc: (op <= 4'd4) ? acc + W : acc});
    if (op <= 4'd4)
      wq.push_back('{first: acc, a: a, b: b, sel: (op == 4'd4) ? 4'b0011 : op});
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() > 0 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
      wq.delete();
    end
    bus.start = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] r, input logic c, input logic e);
    drive_op(op, a, b, cin, r, c, e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain();
  endtask

  initial begin
    int acc;
    bus.start  = 1'b0;
    bus.op_sel = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.op_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;

    issue(4'b0010, 8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0);
    issue(4'b0010, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
    issue(4'b0011, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    issue(4'b0011, 8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);
    issue(4'b0011, 8'h20, 8'h10, 1'b1, 8'h0F, 1'b0, 1'b0);
    issue(4'b0100, 8'h05, 8'h07, 1'b0, 8'h01, 1'b1, 1'b0);
    issue(4'b0100, 8'h07, 8'h07, 1'b1, 8'h00, 1'b0, 1'b0);
    issue(4'b0000, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0);
    issue(4'b0001, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0);
    issue(4'b1001, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b0, 1'b1);

    // start held high: a second accept only after DONE -> IDLE.
    acc = cyc + 1;
    drive_op(4'b0010, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    sb.push_back('{result: 8'h33, carry: 1'b0, err: 1'b0, cyc: acc + 2 * W + 2});
    wq.push_back('{first: acc + W + 2, a: 8'h11, b: 8'h22, sel: 4'b0010});
    wait_drain();

    // Reset in RUN cycle 4 discards the operation.
    acc = cyc + 1;
    drive_op(4'b0010, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("reset_point", cyc, acc + 3);
    rst_n = 1'b0;
    sb.delete();
    wq.delete();
    @(posedge clk); #1;
    check_reset_outputs("mid_run_reset");
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    #1;

    issue(4'b0010, 8'h5A, 8'h5A, 1'b0, 8'hB4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
